// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
//   Tracks the destination registers of instructions that have left ID and
//   decides, for the instruction currently in ID, whether it must be frozen,
//   squashed, or fed through a forwarding path.
//
//   Entry 0 holds the instruction in EXE; entry i is i stages further down.
//   The scoreboard shifts every clock and never holds. A frozen or squashed
//   ID slot enters entry 0 as a bubble.
//
// Ports
//   clk           sole clock, rising edge
//   rst           synchronous reset, active low
//   id_valid      ID holds a real instruction
//   id_src1/2     source register numbers
//   id_src1/2_used source is actually read
//   id_dest       destination register
//   id_wb_en      instruction writes back
//   id_mem_read   instruction is a load
//   branch_taken  EXE resolved a taken branch this cycle
//   freeze        hold PC and IF/ID
//   flush         squash IF/ID and the issuing ID instruction
//   fwd_sel1/2    0 = register file, k = forward from entry k-1
//   stall_count   saturating count of hazard-stall cycles
// ---------------------------------------------------------------------------
module hazard_scoreboard #(
    parameter int REG_AW = 4,
    parameter int DEPTH  = 3,
    parameter int FWD_EN = 0,
    parameter int SEL_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_src1,
    input  logic [REG_AW-1:0] id_src2,
    input  logic              id_src1_used,
    input  logic              id_src2_used,
    input  logic [REG_AW-1:0] id_dest,
    input  logic              id_wb_en,
    input  logic              id_mem_read,
    input  logic              branch_taken,
    output logic              freeze,
    output logic              flush,
    output logic [SEL_W-1:0]  fwd_sel1,
    output logic [SEL_W-1:0]  fwd_sel2,
    output logic [15:0]       stall_count
);

    logic [DEPTH-1:0]  ent_valid;
    logic [DEPTH-1:0]  ent_wb_en;
    logic [DEPTH-1:0]  ent_load;
    logic [REG_AW-1:0] ent_dest [DEPTH];

    logic [DEPTH-1:0]  match1;
    logic [DEPTH-1:0]  match2;
    logic [DEPTH-1:0]  fwd_ok1;
    logic [DEPTH-1:0]  fwd_ok2;
    logic              hazard;
    logic [SEL_W-1:0]  sel1;
    logic [SEL_W-1:0]  sel2;

    // Lowest matching index wins: the youngest producer holds the newest value.
    function automatic logic [SEL_W-1:0] pick_youngest(input logic [DEPTH-1:0] m);
        logic [SEL_W-1:0] s;
        s = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (m[i]) s = SEL_W'(i + 1);
        end
        return s;
    endfunction

    always_comb begin
        match1 = '0;
        match2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match1[i] = ent_valid[i] && ent_wb_en[i] && (ent_dest[i] == id_src1) && id_src1_used;
            match2[i] = ent_valid[i] && ent_wb_en[i] && (ent_dest[i] == id_src2) && id_src2_used;
        end
    end

    // A load in EXE has no data yet, so it can never be a forwarding source.
    always_comb begin
        fwd_ok1    = match1;
        fwd_ok2    = match2;
        fwd_ok1[0] = match1[0] & ~ent_load[0];
        fwd_ok2[0] = match2[0] & ~ent_load[0];
    end

    always_comb begin
        if (FWD_EN == 0)
            hazard = id_valid && ((|match1) || (|match2));
        else
            hazard = id_valid && ent_load[0] && (match1[0] || match2[0]);
    end

    assign sel1 = (FWD_EN != 0) ? pick_youngest(fwd_ok1) : '0;
    assign sel2 = (FWD_EN != 0) ? pick_youngest(fwd_ok2) : '0;

    // Outputs are forced quiet while reset is held; flush beats freeze.
    assign flush    = rst & branch_taken;
    assign freeze   = rst & hazard & ~branch_taken;
    assign fwd_sel1 = rst ? sel1 : '0;
    assign fwd_sel2 = rst ? sel2 : '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            ent_valid   <= '0;
            ent_wb_en   <= '0;
            ent_load    <= '0;
            for (int i = 0; i < DEPTH; i++) ent_dest[i] <= '0;
            stall_count <= '0;
        end else begin
            ent_valid[0] <= id_valid & ~hazard & ~branch_taken;
            ent_dest[0]  <= id_dest;
            ent_wb_en[0] <= id_wb_en;
            ent_load[0]  <= id_mem_read;
            for (int i = 1; i < DEPTH; i++) begin
                ent_valid[i] <= ent_valid[i-1];
                ent_dest[i]  <= ent_dest[i-1];
                ent_wb_en[i] <= ent_wb_en[i-1];
                ent_load[i]  <= ent_load[i-1];
            end
            if (freeze && (stall_count != 16'hFFFF))
                stall_count <= stall_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [3:0] id_src1, id_src2, id_dest;
    logic       id_src1_used, id_src2_used, id_wb_en, id_mem_read;
    logic       branch_taken;

    logic       s_freeze, s_flush, f_freeze, f_flush, d_freeze, d_flush;
    logic [1:0] s_sel1, s_sel2, f_sel1, f_sel2;
    logic [3:0] d_sel1, d_sel2;
    logic [15:0] s_count, f_count, d_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(.REG_AW(4), .DEPTH(3), .FWD_EN(0), .SEL_W(2)) u_stall (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_src1(id_src1), .id_src2(id_src2),
        .id_src1_used(id_src1_used), .id_src2_used(id_src2_used),
        .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_read(id_mem_read),
        .branch_taken(branch_taken),
        .freeze(s_freeze), .flush(s_flush),
        .fwd_sel1(s_sel1), .fwd_sel2(s_sel2), .stall_count(s_count));

    hazard_scoreboard #(.REG_AW(4), .DEPTH(3), .FWD_EN(1), .SEL_W(2)) u_fwd (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_src1(id_src1), .id_src2(id_src2),
        .id_src1_used(id_src1_used), .id_src2_used(id_src2_used),
        .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_read(id_mem_read),
        .branch_taken(branch_taken),
        .freeze(f_freeze), .flush(f_flush),
        .fwd_sel1(f_sel1), .fwd_sel2(f_sel2), .stall_count(f_count));

    // Deep stall-only instance: 8 stall cycles per issue makes saturation reachable quickly.
    hazard_scoreboard #(.REG_AW(4), .DEPTH(8), .FWD_EN(0), .SEL_W(4)) u_deep (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_src1(id_src1), .id_src2(id_src2),
        .id_src1_used(id_src1_used), .id_src2_used(id_src2_used),
        .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_read(id_mem_read),
        .branch_taken(branch_taken),
        .freeze(d_freeze), .flush(d_flush),
        .fwd_sel1(d_sel1), .fwd_sel2(d_sel2), .stall_count(d_count));

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [3:0] s1, input logic u1,
                          input logic [3:0] s2, input logic u2,
                          input logic [3:0] d, input logic wb, input logic ld);
        id_valid     = v;
        id_src1      = s1;
        id_src1_used = u1;
        id_src2      = s2;
        id_src2_used = u2;
        id_dest      = d;
        id_wb_en     = wb;
        id_mem_read  = ld;
        #1;
    endtask

    task automatic do_reset();
        rst          = 1'b0;
        branch_taken = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b1;
    endtask

    initial begin
        // Reset: outputs forced quiet even with a branch and a reader present.
        rst          = 1'b0;
        branch_taken = 1'b1;
        set_id(1, 1, 1, 2, 1, 3, 1, 0);
        tick();
        chk("rst_flush", s_flush, 0);
        chk("rst_freeze", s_freeze, 0);
        chk("rst_fwd_flush", f_flush, 0);
        chk("rst_count", s_count, 0);
        branch_taken = 1'b0;

        // Stall-only RAW: ADD R1 then reader of R1, three stall cycles.
        do_reset();
        set_id(1, 0, 0, 0, 0, 1, 1, 0);
        chk("raw_c0_freeze", s_freeze, 0);
        tick();
        set_id(1, 1, 1, 0, 0, 5, 1, 0);
        chk("raw_c1_freeze", s_freeze, 1);
        chk("raw_c1_nofwd_sel", s_sel1, 0);
        chk("raw_fwd_freeze", f_freeze, 0);
        chk("raw_fwd_sel1", f_sel1, 1);
        tick();
        chk("raw_c2_freeze", s_freeze, 1);
        tick();
        chk("raw_c3_freeze", s_freeze, 1);
        tick();
        chk("raw_c4_freeze", s_freeze, 0);
        chk("raw_count", s_count, 3);

        // Reset mid-stall discards in-flight entries.
        do_reset();
        set_id(1, 0, 0, 0, 0, 1, 1, 0);
        tick();
        set_id(1, 1, 1, 0, 0, 5, 1, 0);
        chk("midrst_freeze", s_freeze, 1);
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("midrst_after_freeze", s_freeze, 0);
        chk("midrst_after_count", s_count, 0);

        // Forwarding: ADD R2, SUB reads R2 as src2, then a later reader.
        do_reset();
        set_id(1, 0, 0, 0, 0, 2, 1, 0);
        tick();
        set_id(1, 7, 1, 2, 1, 6, 1, 0);
        chk("fwd_sub_freeze", f_freeze, 0);
        chk("fwd_sub_sel2", f_sel2, 1);
        chk("fwd_sub_sel1", f_sel1, 0);
        tick();
        set_id(1, 2, 1, 0, 0, 8, 1, 0);
        chk("fwd_next_sel1", f_sel1, 2);
        chk("stall_sel1_zero", s_sel1, 0);

        // Load-use: one stall cycle then forward from entry 1.
        do_reset();
        set_id(1, 0, 0, 0, 0, 3, 1, 1);
        tick();
        set_id(1, 3, 1, 0, 0, 9, 1, 0);
        chk("ld_c1_freeze", f_freeze, 1);
        tick();
        chk("ld_c2_freeze", f_freeze, 0);
        chk("ld_c2_sel1", f_sel1, 2);
        chk("ld_count", f_count, 1);

        // Hazard and taken branch together: flush wins, bubble enters.
        do_reset();
        set_id(1, 0, 0, 0, 0, 1, 1, 0);
        tick();
        set_id(1, 1, 1, 0, 0, 10, 1, 0);
        branch_taken = 1'b1;
        #1;
        chk("br_flush", s_flush, 1);
        chk("br_freeze", s_freeze, 0);
        tick();
        branch_taken = 1'b0;
        set_id(1, 10, 1, 1, 1, 11, 1, 0);
        chk("br_count", s_count, 0);
        chk("br_bubble_sel1", f_sel1, 0);
        chk("br_old_sel2", f_sel2, 2);

        // Youngest producer wins; unused source never forwards.
        do_reset();
        set_id(1, 0, 0, 0, 0, 4, 1, 0);
        tick();
        set_id(1, 0, 0, 0, 0, 4, 1, 0);
        tick();
        set_id(1, 4, 1, 4, 0, 12, 1, 0);
        chk("young_sel1", f_sel1, 1);
        chk("unused_sel2", f_sel2, 0);

        // Producer with wb_en=0: no hazard, no forwarding.
        do_reset();
        set_id(1, 0, 0, 0, 0, 4, 0, 0);
        tick();
        set_id(1, 4, 1, 4, 1, 12, 1, 0);
        chk("nowb_freeze", s_freeze, 0);
        chk("nowb_sel1", f_sel1, 0);
        chk("nowb_sel2", f_sel2, 0);

        // Saturation: self-dependent instruction held in ID keeps the deep
        // instance stalling 8 of every 9 cycles.
        do_reset();
        set_id(1, 1, 1, 0, 0, 1, 1, 0);
        for (int i = 0; i < 74000; i++) tick();
        chk("sat_count", d_count, 16'hFFFF);
        for (int i = 0; i < 9; i++) tick();
        chk("sat_hold", d_count, 16'hFFFF);
        rst = 1'b0;
        tick();
        chk("sat_rst", d_count, 0);
        rst = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter REG_AW, default 4, register-address width.
REQ-002 Parameter DEPTH, default 3, in-flight stages tracked beyond ID (legal range 1-8).
REQ-003 Parameter FWD_EN, default 0: 0 = stall-only; 1 = forwarding with load-use stall.
REQ-004 Parameter SEL_W, default 2, forward-select width; SEL_W SHALL equal clog2(DEPTH+1).
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous, active-low reset.
REQ-007 id_valid  input  1  ID holds a real instruction.
REQ-008 id_src1, id_src2  input  REG_AW each  source register numbers.
REQ-009 id_src1_used, id_src2_used  input  1 each  source is actually read.
REQ-010 id_dest  input  REG_AW  destination register.
REQ-011 id_wb_en  input  1  instruction writes back.
REQ-012 id_mem_read  input  1  instruction is a load.
REQ-013 branch_taken  input  1  EXE resolved a taken branch this cycle.
REQ-014 freeze  output  1  hold PC and IF/ID register.
REQ-015 flush  output  1  squash IF/ID and the issuing ID instruction.
REQ-016 fwd_sel1, fwd_sel2  output  SEL_W each  0 = register file; k = entry k-1.
REQ-017 stall_count  output  16  saturating count of hazard-stall cycles.

Function
REQ-018 Scoreboard: DEPTH entries {valid, dest, wb_en, is_load}; entry 0 = instruction currently in EXE, entry i = i stages further.
REQ-019 Entry i (i≥1) SHALL load entry i-1 every clock; entries never hold.
REQ-020 Match(i, s) SHALL be: entry i valid, wb_en=1, dest==s, and source s used.
REQ-021 FWD_EN=0: hazard SHALL be 1 when id_valid and Match(i, src1 or src2) for any i.
REQ-022 FWD_EN=1: hazard SHALL be 1 only when id_valid and entry 0 is_load and Match(0, src1 or src2).
REQ-023 FWD_EN=1: fwd_selN SHALL be 1+lowest i with Match(i, srcN) excluding a load in entry 0; otherwise 0.
REQ-024 FWD_EN=0: fwd_sel1 and fwd_sel2 SHALL be 0 at all times.
REQ-025 flush SHALL equal branch_taken (combinational, same cycle).
REQ-026 freeze SHALL equal hazard AND NOT branch_taken; flush has priority.
REQ-027 Entry 0 next SHALL be a bubble (valid=0) when id_valid=0, hazard=1, or branch_taken=1.
REQ-028 Otherwise entry 0 next SHALL capture {1, id_dest, id_wb_en, id_mem_read}.
REQ-029 freeze, flush and fwd_sel SHALL be combinational from current entries and inputs; latency 0 cycles.
REQ-030 stall_count SHALL increment when freeze=1.
REQ-031 stall_count SHALL hold at 16'hFFFF.
REQ-032 A register matched in several entries SHALL forward from the youngest (lowest index).
REQ-033 A source equal to a destination with wb_en=0 SHALL cause neither a hazard nor forwarding.

Reset
REQ-034 While rst=0 at a clock edge, all entries SHALL become invalid and stall_count SHALL become 0.
REQ-035 While rst=0, freeze, flush, fwd_sel1 and fwd_sel2 SHALL be forced to 0.
REQ-036 Reset asserted mid-stall SHALL discard all in-flight entries; the first cycle after release SHALL see an empty scoreboard.

Verification
REQ-037 FWD_EN=0, DEPTH=3: issue ADD R1; next issue uses R1 -> freeze=1 for 3 cycles, then 0; stall_count=3.
REQ-038 FWD_EN=1: ADD R2, then SUB using R2 as src2 -> freeze=0, fwd_sel2=1; one cycle later a reader of R2 gets fwd_sel=2.
REQ-039 FWD_EN=1: LDR R3, then a reader of R3 -> freeze=1 for exactly 1 cycle, then fwd_sel=2, stall_count=1.
REQ-040 Hazard and branch_taken=1 in the same cycle -> flush=1, freeze=0, entry 0 bubble, stall_count unchanged.
REQ-041 Drive 70000 consecutive hazard cycles -> stall_count saturates at 16'hFFFF; rst=0 -> 0 next edge.
REQ-042 ADD R4 in entry 1 and MOV R4 in entry 0, then a reader of R4 -> fwd_sel=1; with id_wb_en=0 for R4 -> no stall and fwd_sel=0.
